// File: rtl/sequence_pkg.sv
//------------------------------------------------------------------------------
// sequence_pkg : shared phase encodings and default widths for sequence_controller
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package sequence_pkg;

  localparam int unsigned DEF_ADDR_W = 14;
  localparam int unsigned DEF_CNT_W  = 16;

  localparam logic [2:0] PH_IDLE      = 3'd0;
  localparam logic [2:0] PH_RAMP_UP   = 3'd1;
  localparam logic [2:0] PH_HOLD      = 3'd2;
  localparam logic [2:0] PH_RAMP_DOWN = 3'd3;
  localparam logic [2:0] PH_DONE      = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE      = PH_IDLE,
    S_RAMP_UP   = PH_RAMP_UP,
    S_HOLD      = PH_HOLD,
    S_RAMP_DOWN = PH_RAMP_DOWN,
    S_DONE      = PH_DONE
  } state_t;

endpackage

`default_nettype wire

// File: rtl/step_detect.sv
//------------------------------------------------------------------------------
// step_detect : samples the stepper counter and flags step / skipped-step events
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module step_detect (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_seq,
  output logic        o_step,
  output logic        o_skip
);

  logic [31:0] r_seq_q;
  logic [31:0] r_seq_prev;
  logic [31:0] w_delta;

  // Both stages load the live input in reset so no phantom step follows release.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seq_q    <= i_seq;
      r_seq_prev <= i_seq;
    end else begin
      r_seq_q    <= i_seq;
      r_seq_prev <= r_seq_q;
    end
  end

  assign w_delta = r_seq_q - r_seq_prev;
  assign o_step  = (r_seq_q != r_seq_prev);
  assign o_skip  = (w_delta > 32'd1);

endmodule

`default_nettype wire

// File: rtl/sequence_controller.sv
//------------------------------------------------------------------------------
// sequence_controller : ramp-up / hold / ramp-down phase scheduler driven by steps
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sequence_controller
  import sequence_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              areset,
  input  logic [31:0]       seq_counter,
  input  logic [ADDR_W-1:0] period_len,
  input  logic [CNT_W-1:0]  ramp_up_periods,
  input  logic [CNT_W-1:0]  hold_periods,
  input  logic [CNT_W-1:0]  ramp_down_periods,
  input  logic              start,
  input  logic              stop,
  output logic [ADDR_W-1:0] lut_addr,
  output logic [CNT_W-1:0]  period_count,
  output logic [2:0]        phase,
  output logic              step_valid,
  output logic              dac_enable,
  output logic              ramp_active,
  output logic              busy,
  output logic              done,
  output logic              skip_err
);

  logic w_step;
  logic w_skip;

  step_detect u_step_detect (
    .clk    (clk),
    .rst    (areset),
    .i_seq  (seq_counter),
    .o_step (w_step),
    .o_skip (w_skip)
  );

  state_t            r_state;
  logic [ADDR_W-1:0] r_cfg_len;
  logic [CNT_W-1:0]  r_cfg_up;
  logic [CNT_W-1:0]  r_cfg_hold;
  logic [CNT_W-1:0]  r_cfg_down;
  logic [ADDR_W-1:0] r_lut;
  logic [CNT_W-1:0]  r_pc;
  logic              r_stop_pending;
  logic              r_skip_err;
  logic              r_step_valid;
  logic              r_dac_enable;
  logic              r_ramp_active;
  logic              r_done;

  logic              w_start_acc;
  logic              w_stop_eff;
  logic [ADDR_W-1:0] w_plen_m1;
  logic [CNT_W-1:0]  w_target;
  logic [CNT_W:0]    w_pc_plus;
  logic [CNT_W-1:0]  w_pc_sat;
  logic              w_phase_end;
  state_t            w_exit_state;

  state_t            w_nx_state;
  logic [ADDR_W-1:0] w_nx_lut;
  logic [CNT_W-1:0]  w_nx_pc;
  logic              w_nx_stop;
  logic              w_nx_skip;
  logic              w_nx_valid;

  assign w_start_acc  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_stop_eff   = r_stop_pending ||
                        (stop && ((r_state == S_RAMP_UP) || (r_state == S_HOLD)));
  // A zero period length behaves as a one-step period.
  assign w_plen_m1    = (r_cfg_len == '0) ? '0 : r_cfg_len - 1'b1;
  assign w_pc_plus    = {1'b0, r_pc} + 1'b1;
  assign w_pc_sat     = (&r_pc) ? r_pc : w_pc_plus[CNT_W-1:0];
  assign w_exit_state = (r_cfg_down != '0) ? S_RAMP_DOWN : S_DONE;

  always_comb begin
    w_target = r_cfg_down;
    case (r_state)
      S_RAMP_UP: w_target = r_cfg_up;
      S_HOLD:    w_target = r_cfg_hold;
      default:   w_target = r_cfg_down;
    endcase
  end

  // Hold with zero periods never matches the count, so only stop can end it.
  assign w_phase_end = (w_pc_plus == {1'b0, w_target}) ||
                       ((r_state == S_HOLD) && w_stop_eff);

  always_comb begin
    w_nx_state = r_state;
    w_nx_lut   = r_lut;
    w_nx_pc    = r_pc;
    w_nx_stop  = r_stop_pending;
    w_nx_skip  = r_skip_err || (w_step && w_skip);
    w_nx_valid = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_nx_state = (ramp_up_periods != '0) ? S_RAMP_UP : S_HOLD;
          w_nx_lut   = '0;
          w_nx_pc    = '0;
          w_nx_stop  = 1'b0;
          w_nx_skip  = 1'b0;
        end
      end
      S_RAMP_UP, S_HOLD, S_RAMP_DOWN: begin
        w_nx_stop = w_stop_eff;
        if (w_step) begin
          w_nx_valid = 1'b1;
          if (r_lut == w_plen_m1) begin
            w_nx_lut = '0;
            if (w_phase_end) begin
              w_nx_pc = '0;
              case (r_state)
                S_RAMP_UP: w_nx_state = w_stop_eff ? w_exit_state : S_HOLD;
                S_HOLD:    w_nx_state = w_exit_state;
                default:   w_nx_state = S_DONE;
              endcase
            end else begin
              w_nx_pc = w_pc_sat;
            end
          end else begin
            w_nx_lut = r_lut + 1'b1;
          end
        end
      end
      default: w_nx_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      r_state        <= S_IDLE;
      r_cfg_len      <= '0;
      r_cfg_up       <= '0;
      r_cfg_hold     <= '0;
      r_cfg_down     <= '0;
      r_lut          <= '0;
      r_pc           <= '0;
      r_stop_pending <= 1'b0;
      r_skip_err     <= 1'b0;
      r_step_valid   <= 1'b0;
      r_dac_enable   <= 1'b0;
      r_ramp_active  <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      if (w_start_acc) begin
        r_cfg_len  <= period_len;
        r_cfg_up   <= ramp_up_periods;
        r_cfg_hold <= hold_periods;
        r_cfg_down <= ramp_down_periods;
      end
      r_state        <= w_nx_state;
      r_lut          <= w_nx_lut;
      r_pc           <= w_nx_pc;
      r_stop_pending <= w_nx_stop;
      r_skip_err     <= w_nx_skip;
      r_step_valid   <= w_nx_valid;
      r_dac_enable   <= (w_nx_state == S_RAMP_UP) || (w_nx_state == S_HOLD) ||
                        (w_nx_state == S_RAMP_DOWN);
      r_ramp_active  <= (w_nx_state == S_RAMP_UP) || (w_nx_state == S_RAMP_DOWN);
      r_done         <= (w_nx_state == S_DONE);
    end
  end

  assign lut_addr     = r_lut;
  assign period_count = r_pc;
  assign phase        = r_state;
  assign step_valid   = r_step_valid;
  assign dac_enable   = r_dac_enable;
  assign ramp_active  = r_ramp_active;
  assign busy         = r_dac_enable;
  assign done         = r_done;
  assign skip_err     = r_skip_err;

endmodule

`default_nettype wire

// File: tb/tb_sequence_controller.sv
//------------------------------------------------------------------------------
// tb_sequence_controller : directed self-checking bench for sequence_controller
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_sequence_controller;

  logic        clk;
  logic        areset;
  logic [31:0] seq_counter;
  logic [13:0] period_len;
  logic [15:0] ramp_up_periods;
  logic [15:0] hold_periods;
  logic [15:0] ramp_down_periods;
  logic        start;
  logic        stop;
  logic [13:0] lut_addr;
  logic [15:0] period_count;
  logic [2:0]  phase;
  logic        step_valid;
  logic        dac_enable;
  logic        ramp_active;
  logic        busy;
  logic        done;
  logic        skip_err;

  int checks;
  int failures;

  sequence_controller dut (
    .clk               (clk),
    .areset            (areset),
    .seq_counter       (seq_counter),
    .period_len        (period_len),
    .ramp_up_periods   (ramp_up_periods),
    .hold_periods      (hold_periods),
    .ramp_down_periods (ramp_down_periods),
    .start             (start),
    .stop              (stop),
    .lut_addr          (lut_addr),
    .period_count      (period_count),
    .phase             (phase),
    .step_valid        (step_valid),
    .dac_enable        (dac_enable),
    .ramp_active       (ramp_active),
    .busy              (busy),
    .done              (done),
    .skip_err          (skip_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
  endtask

  task automatic do_step(input int delta);
    seq_counter = seq_counter + delta;
    tick(2);
  endtask

  task automatic config_seq(input int len, input int up, input int hold, input int down);
    period_len        = len[13:0];
    ramp_up_periods   = up[15:0];
    hold_periods      = hold[15:0];
    ramp_down_periods = down[15:0];
  endtask

  task automatic test_reset();
    areset = 1'b1; start = 1'b0; stop = 1'b0; seq_counter = 32'd100;
    config_seq(4, 2, 3, 1);
    tick(2);
    seq_counter = 32'd200;
    tick(1);
    areset = 1'b0;
    tick(1);
    checks++;
    if ({phase, lut_addr, period_count} !== 33'd0) begin
      failures++;
      $display("FAIL reset_counters phase=%0d lut=%0d pc=%0d exp all 0", phase, lut_addr, period_count);
    end
    checks++;
    if ({step_valid, dac_enable, ramp_active, busy, done, skip_err} !== 6'd0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=000000",
               {step_valid, dac_enable, ramp_active, busy, done, skip_err});
    end
    tick(3);
    checks++;
    if ({phase, step_valid, skip_err} !== 5'd0) begin
      failures++;
      $display("FAIL reset_no_spurious phase=%0d valid=%b skip=%b exp 0", phase, step_valid, skip_err);
    end
  endtask

  task automatic test_full_sequence();
    int exp_ph, exp_pc;
    config_seq(4, 2, 3, 1);
    pulse_start();
    checks++;
    if ({phase, lut_addr, period_count, dac_enable, ramp_active, busy, done} !== {3'd1, 14'd0, 16'd0, 4'b1110}) begin
      failures++;
      $display("FAIL start_state phase=%0d lut=%0d pc=%0d en=%b ramp=%b busy=%b done=%b exp 1/0/0/1110",
               phase, lut_addr, period_count, dac_enable, ramp_active, busy, done);
    end
    period_len = 14'd7;  // latched config must not change
    for (int i = 1; i <= 24; i++) begin
      do_step(1);
      exp_ph = (i < 8) ? 1 : (i < 20) ? 2 : (i < 24) ? 3 : 4;
      exp_pc = (i < 8) ? i / 4 : (i < 20) ? (i - 8) / 4 : 0;
      checks++;
      if (phase !== exp_ph[2:0] || lut_addr !== 14'(i % 4) || period_count !== exp_pc[15:0]) begin
        failures++;
        $display("FAIL full_step%0d phase=%0d lut=%0d pc=%0d exp %0d/%0d/%0d",
                 i, phase, lut_addr, period_count, exp_ph, i % 4, exp_pc);
      end
      checks++;
      if (step_valid !== 1'b1 || dac_enable !== (exp_ph != 4) ||
          ramp_active !== (exp_ph == 1 || exp_ph == 3)) begin
        failures++;
        $display("FAIL full_flags%0d valid=%b en=%b ramp=%b exp 1/%b/%b", i, step_valid,
                 dac_enable, ramp_active, exp_ph != 4, exp_ph == 1 || exp_ph == 3);
      end
      tick(1);
      checks++;
      if (step_valid !== 1'b0) begin
        failures++;
        $display("FAIL full_pulse%0d valid=%b exp 0", i, step_valid);
      end
      tick(1);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL full_done done=%b busy=%b exp 1/0", done, busy);
    end
  endtask

  task automatic test_stop_hold();
    config_seq(4, 0, 0, 1);
    start = 1'b1; stop = 1'b1;
    tick(1);
    start = 1'b0; stop = 1'b0;
    checks++;
    if (phase !== 3'd2 || ramp_active !== 1'b0) begin
      failures++;
      $display("FAIL hold_entry phase=%0d ramp=%b exp 2/0", phase, ramp_active);
    end
    for (int i = 1; i <= 10; i++) do_step(1);
    checks++;
    if (phase !== 3'd2 || lut_addr !== 14'd2 || period_count !== 16'd2) begin
      failures++;
      $display("FAIL hold_run phase=%0d lut=%0d pc=%0d exp 2/2/2", phase, lut_addr, period_count);
    end
    pulse_stop();
    do_step(1);
    checks++;
    if (phase !== 3'd2 || lut_addr !== 14'd3) begin
      failures++;
      $display("FAIL hold_stop11 phase=%0d lut=%0d exp 2/3", phase, lut_addr);
    end
    do_step(1);
    checks++;
    if (phase !== 3'd3 || lut_addr !== 14'd0 || period_count !== 16'd0) begin
      failures++;
      $display("FAIL hold_stop12 phase=%0d lut=%0d pc=%0d exp 3/0/0", phase, lut_addr, period_count);
    end
    for (int i = 0; i < 4; i++) do_step(1);
    checks++;
    if (phase !== 3'd4) begin
      failures++;
      $display("FAIL hold_done phase=%0d exp 4", phase);
    end
  endtask

  task automatic test_stop_ramp();
    config_seq(4, 2, 5, 1);
    pulse_start();
    for (int i = 1; i <= 3; i++) do_step(1);
    pulse_stop();
    for (int i = 4; i <= 7; i++) do_step(1);
    checks++;
    if (phase !== 3'd1 || lut_addr !== 14'd3 || period_count !== 16'd1) begin
      failures++;
      $display("FAIL ramp_stop7 phase=%0d lut=%0d pc=%0d exp 1/3/1", phase, lut_addr, period_count);
    end
    do_step(1);
    checks++;
    if (phase !== 3'd3 || ramp_active !== 1'b1) begin
      failures++;
      $display("FAIL ramp_stop8 phase=%0d ramp=%b exp 3/1", phase, ramp_active);
    end
    for (int i = 0; i < 4; i++) do_step(1);
    checks++;
    if (phase !== 3'd4 || done !== 1'b1) begin
      failures++;
      $display("FAIL ramp_done phase=%0d done=%b exp 4/1", phase, done);
    end
  endtask

  task automatic test_skip();
    config_seq(2, 0, 0, 0);
    seq_counter = 32'd5;
    tick(3);
    pulse_start();
    seq_counter = 32'd8;
    tick(2);
    checks++;
    if (step_valid !== 1'b1 || lut_addr !== 14'd1 || skip_err !== 1'b1) begin
      failures++;
      $display("FAIL skip_jump valid=%b lut=%0d skip=%b exp 1/1/1", step_valid, lut_addr, skip_err);
    end
    tick(1);
    checks++;
    if (step_valid !== 1'b0) begin
      failures++;
      $display("FAIL skip_single valid=%b exp 0", step_valid);
    end
    pulse_stop();
    do_step(1);
    checks++;
    if (phase !== 3'd4 || done !== 1'b1 || skip_err !== 1'b1 || dac_enable !== 1'b0) begin
      failures++;
      $display("FAIL skip_zero_down phase=%0d done=%b skip=%b en=%b exp 4/1/1/0",
               phase, done, skip_err, dac_enable);
    end
    pulse_start();
    checks++;
    if (skip_err !== 1'b0 || phase !== 3'd2) begin
      failures++;
      $display("FAIL skip_clear skip=%b phase=%0d exp 0/2", skip_err, phase);
    end
  endtask

  task automatic test_areset_hold();
    areset = 1'b1;
    tick(1);
    areset = 1'b0;
    config_seq(4, 0, 0, 1);
    pulse_start();
    do_step(1);
    do_step(1);
    checks++;
    if (phase !== 3'd2 || lut_addr !== 14'd2) begin
      failures++;
      $display("FAIL areset_pre phase=%0d lut=%0d exp 2/2", phase, lut_addr);
    end
    areset = 1'b1;
    tick(1);
    checks++;
    if ({phase, lut_addr, period_count, step_valid, dac_enable, ramp_active, busy, done, skip_err} !== 39'd0) begin
      failures++;
      $display("FAIL areset_clear phase=%0d lut=%0d pc=%0d en=%b busy=%b exp all 0",
               phase, lut_addr, period_count, dac_enable, busy);
    end
    areset = 1'b0;
    tick(1);
    pulse_start();
    do_step(1);
    checks++;
    if (phase !== 3'd2 || lut_addr !== 14'd1) begin
      failures++;
      $display("FAIL areset_restart phase=%0d lut=%0d exp 2/1", phase, lut_addr);
    end
    areset = 1'b1;
    tick(1);
    areset = 1'b0;
    tick(1);
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    config_seq(4, 1, 1, 1);
    pulse_start();
    for (int i = 0; i < 12; i++) begin
      if (step_valid === 1'b1) pulses++;
      start = (i == 5);
      seq_counter = seq_counter + 1;
      tick(1);
    end
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (step_valid === 1'b1) pulses++;
      tick(1);
    end
    checks++;
    if (pulses !== 12) begin
      failures++;
      $display("FAIL b2b_pulses got=%0d exp=12", pulses);
    end
    checks++;
    if (phase !== 3'd4 || done !== 1'b1 || lut_addr !== 14'd0) begin
      failures++;
      $display("FAIL b2b_done phase=%0d done=%b lut=%0d exp 4/1/0", phase, done, lut_addr);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_full_sequence();
    test_stop_hold();
    test_stop_ramp();
    test_skip();
    test_areset_hold();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
